// File: rtl/seq_pkg.sv
// Shared definitions for the consecutive-number generator/checker pair.
// state_t : two-state block controller (COLLECT samples / REPORT result)
// mod_add : (a + k) mod size for a < size and k < size, one conditional subtract
package seq_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    // The sum is formed at full 32-bit width, so it cannot wrap when SIZE is
    // not a power of two.
    function automatic logic [31:0] mod_add(input logic [31:0] a,
                                            input logic [31:0] k,
                                            input logic [31:0] size);
        logic [31:0] s;
        s = a + k;
        return (s >= size) ? (s - size) : s;
    endfunction

endpackage

// File: rtl/consecutive_checker.sv
// consecutive_checker
// Groups an incoming valid/ready stream into blocks of GROUP samples. It
// checks that each block is a run of consecutive values modulo SIZE, then
// reports the block's first value, a pass flag and the index of the first
// offending sample.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clear     synchronous abort of the current block, also zeroes pass_cnt
//   in_valid  num_in valid
//   in_ready  checker can accept a sample (COLLECT)
//   num_in    sample value, W bits
//   out_valid block result valid (REPORT)
//   out_ready result consumer ready
//   base_out  first sample of the block
//   match     1 = all samples consecutive mod SIZE
//   bad_idx   index of first mismatching sample, GROUP when match
//   pass_cnt  saturating count of matching blocks
//
// state   | meaning
// COLLECT | accepting samples, cnt = samples taken so far in the block
// REPORT  | result held on outputs until out_ready
module consecutive_checker
    import seq_pkg::*;
#(
    parameter int  SIZE  = 16,
    parameter int  GROUP = 4,
    parameter int  CNT_W = 8,
    localparam int W     = $clog2(SIZE),
    localparam int CW    = $clog2(GROUP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     num_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     base_out,
    output logic             match,
    output logic [CW-1:0]    bad_idx,
    output logic [CNT_W-1:0] pass_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_base;
    logic             r_ok;
    logic             r_match;
    logic [CW-1:0]    r_bad_idx;
    logic [CNT_W-1:0] r_pass_cnt;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_first;
    logic             w_last;
    logic             w_in_range;
    logic [W-1:0]     w_expected;
    logic             w_hit;
    logic             w_ok_nxt;

    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == CW'(GROUP - 1));
    // Compared at 32 bits so out-of-range codes are caught when SIZE is not a
    // power of two.
    assign w_in_range = (32'(num_in) < 32'(SIZE));
    assign w_expected = W'(mod_add(32'(r_base), 32'(r_cnt), 32'(SIZE)));
    assign w_hit      = w_in_range && (num_in == w_expected);
    // The first sample only has to be in range; later samples must also follow
    // the run, and once the block has failed it stays failed.
    assign w_ok_nxt   = w_first ? w_in_range : (r_ok && w_hit);
    assign w_accept   = in_valid && w_in_ready && !clear;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            COLLECT: begin
                w_in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = COLLECT;
                end
            end
            default: begin
                w_state_nxt = COLLECT;
            end
        endcase
        if (clear) begin
            w_state_nxt = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_base     <= '0;
            r_ok       <= 1'b0;
            r_match    <= 1'b0;
            r_bad_idx  <= '0;
            r_pass_cnt <= '0;
        end else if (clear) begin
            r_cnt      <= '0;
            r_pass_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_ok <= w_ok_nxt;
                if (w_first) begin
                    r_base    <= num_in;
                    r_bad_idx <= w_in_range ? CW'(GROUP) : '0;
                end else if (r_ok && !w_hit) begin
                    r_bad_idx <= r_cnt;
                end
                if (w_last) begin
                    r_cnt   <= '0;
                    r_match <= w_ok_nxt;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_out_valid && out_ready && r_match &&
                (r_pass_cnt != {CNT_W{1'b1}})) begin
                r_pass_cnt <= r_pass_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign base_out  = r_base;
    assign match     = r_match;
    assign bad_idx   = r_bad_idx;
    assign pass_cnt  = r_pass_cnt;

endmodule

// File: tb/tb_consecutive_checker.sv
module tb_consecutive_checker;

    typedef struct {
        logic [3:0] base;
        logic       match;
        logic [2:0] bad;
        logic [7:0] pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear     [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [3:0] num_in    [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [3:0] base_out  [2];
    logic       match     [2];
    logic [2:0] bad_idx   [2];
    logic [7:0] pass_cnt  [2];

    int   errors = 0;
    int   checks = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    consecutive_checker #(.SIZE(16), .GROUP(4), .CNT_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .num_in(num_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .base_out(base_out[0]), .match(match[0]), .bad_idx(bad_idx[0]),
        .pass_cnt(pass_cnt[0])
    );

    consecutive_checker #(.SIZE(10), .GROUP(4), .CNT_W(8)) dut10 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .num_in(num_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .base_out(base_out[1]), .match(match[1]), .bad_idx(bad_idx[1]),
        .pass_cnt(pass_cnt[1])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input int d, input exp_t e);
        check($sformatf("base_out[%0d]", d), int'(base_out[d]), int'(e.base));
        check($sformatf("match[%0d]", d),    int'(match[d]),    int'(e.match));
        check($sformatf("bad_idx[%0d]", d),  int'(bad_idx[d]),  int'(e.bad));
        check($sformatf("pass_cnt_at_report[%0d]", d), int'(pass_cnt[d]), int'(e.pass));
    endtask

    // Monitor: one result per out_valid/out_ready handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (out_valid[d] && out_ready[d]) begin
                exp_t e;
                if (d == 0) begin
                    if (q0.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_output[0]: base %0d with empty queue", base_out[0]);
                    end else begin
                        e = q0.pop_front();
                        check_out(0, e);
                    end
                end else begin
                    if (q1.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_output[1]: base %0d with empty queue", base_out[1]);
                    end else begin
                        e = q1.pop_front();
                        check_out(1, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [3:0] v);
        int n;
        n = 0;
        in_valid[d] = 1'b1;
        num_in[d]   = v;
        while (!in_ready[d] && n < 50) begin
            step();
            n++;
        end
        if (!in_ready[d]) begin
            errors++; checks++;
            $display("FAIL send_timeout[%0d]: in_ready stuck low, value %0d", d, v);
        end
        step();
        in_valid[d] = 1'b0;
    endtask

    task automatic block(input int d, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] e4,
                         input logic [3:0] eb, input logic em,
                         input logic [2:0] ebad, input logic [7:0] ep);
        exp_t e;
        e.base = eb; e.match = em; e.bad = ebad; e.pass = ep;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        send(d, a);
        send(d, b);
        send(d, c);
        send(d, e4);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            clear[d] = 1'b0; in_valid[d] = 1'b0; num_in[d] = '0; out_ready[d] = 1'b1;
        end
        #1;
        check("reset_in_ready",  int'(in_ready[0]),  1);
        check("reset_out_valid", int'(out_valid[0]), 0);
        check("reset_base",      int'(base_out[0]),  0);
        check("reset_match",     int'(match[0]),     0);
        check("reset_bad_idx",   int'(bad_idx[0]),   0);
        check("reset_pass_cnt",  int'(pass_cnt[0]),  0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic run; result must be visible right after the 4th accept.
        block(0, 3, 4, 5, 6, 3, 1, 4, 0);
        check("latency_out_valid", int'(out_valid[0]), 1);
        step();
        check("pass_after_first", int'(pass_cnt[0]), 1);

        block(0, 14, 15, 0, 1, 14, 1, 4, 1);
        block(0, 5, 6, 9, 8, 5, 0, 2, 2);
        step();
        check("pass_unchanged_on_fail", int'(pass_cnt[0]), 2);

        // SIZE = 10 instance: wrap, out-of-range mid-block and at index 0.
        block(1, 8, 9, 0, 1, 8, 1, 4, 0);
        block(1, 8, 9, 10, 0, 8, 0, 2, 1);
        block(1, 9, 0, 1, 2, 9, 1, 4, 1);
        block(1, 12, 3, 4, 5, 12, 0, 0, 2);
        step();
        check("pass10_final", int'(pass_cnt[1]), 2);

        // Backpressure.
        out_ready[0] = 1'b0;
        block(0, 0, 1, 2, 3, 0, 1, 4, 2);
        in_valid[0] = 1'b1;
        num_in[0]   = 4'd9;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready",  int'(in_ready[0]),  0);
            check("bp_out_valid", int'(out_valid[0]), 1);
            check("bp_base",      int'(base_out[0]),  0);
            check("bp_match",     int'(match[0]),     1);
            check("bp_bad_idx",   int'(bad_idx[0]),   4);
            step();
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        block(0, 10, 11, 12, 13, 10, 1, 4, 3);
        step();
        check("pass_after_bp", int'(pass_cnt[0]), 4);

        // Clear after two accepts; the sample offered alongside clear is dropped.
        send(0, 1);
        send(0, 2);
        clear[0]    = 1'b1;
        in_valid[0] = 1'b1;
        num_in[0]   = 4'd5;
        step();
        clear[0]    = 1'b0;
        in_valid[0] = 1'b0;
        check("clear_pass_cnt",  int'(pass_cnt[0]),  0);
        check("clear_out_valid", int'(out_valid[0]), 0);
        block(0, 7, 8, 9, 10, 7, 1, 4, 0);
        step();
        check("pass_after_clear", int'(pass_cnt[0]), 1);

        // Asynchronous reset mid-block.
        send(0, 2);
        send(0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  int'(in_ready[0]),  1);
        check("arst_out_valid", int'(out_valid[0]), 0);
        check("arst_base",      int'(base_out[0]),  0);
        check("arst_match",     int'(match[0]),     0);
        check("arst_bad_idx",   int'(bad_idx[0]),   0);
        check("arst_pass_cnt",  int'(pass_cnt[0]),  0);
        step();
        rst_n = 1'b1;
        step();
        block(0, 4, 5, 6, 7, 4, 1, 4, 0);
        step();
        check("pass_after_arst", int'(pass_cnt[0]), 1);

        repeat (4) step();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
